// File: rtl/logic_sweep_pkg.sv
// logic_sweep_pkg
//   Shared types for the logic sweep tester.
//   op_e    : gate function codes carried on op_sel (6/7 are illegal)
//   state_e : sweep controller states
//   op_is_legal() : true for the six defined gate functions
package logic_sweep_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLE_W = 2'd1,
        CHECK    = 2'd2,
        DONE     = 2'd3
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= 3'(OP_XNOR);
    endfunction

endpackage

// File: rtl/logic_ref_eval.sv
// logic_ref_eval
//   Combinational golden model of the gate under test.
//   vec    : input vector applied to the gate
//   op     : gate function code (op_e encoding)
//   result : reduction of vec by op; 0 for illegal codes
module logic_ref_eval
    import logic_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] vec,
    input  logic [2:0]      op,
    output logic            result
);

    always_comb begin
        result = 1'b0;
        case (op)
            OP_AND:  result = &vec;
            OP_OR:   result = |vec;
            OP_XOR:  result = ^vec;
            OP_NAND: result = ~&vec;
            OP_NOR:  result = ~|vec;
            OP_XNOR: result = ~^vec;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/logic_sweep_tester.sv
// logic_sweep_tester
//   Exhaustively sweeps all 2^N_IN input vectors of an external gate,
//   holding each vector SETTLE cycles before comparing the gate output
//   against a reference, and reports a mismatch count and first failure.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : one-cycle sweep request (honoured in IDLE only)
//   op_sel     : gate function, latched at start
//   vec_out    : vector driven to the gate under test
//   dut_in     : gate under test output
//   expected   : reference result for vec_out under the latched op
//   busy       : high in SETTLE_W and CHECK
//   done       : one-cycle pulse at sweep end
//   pass       : last sweep had a legal op and no mismatches
//   err_count  : mismatch count of last/current sweep
//   first_fail : vector of first mismatch (valid when err_count != 0)
module logic_sweep_tester
    import logic_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op_sel,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_in,
    output logic            expected,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail
);

    localparam int CW = 4;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    state_e          state;
    logic [2:0]      op_q;
    logic            op_ok_q;
    logic [CW-1:0]   settle_cnt;

    logic_ref_eval #(.N_IN(N_IN)) u_ref (
        .vec    (vec_out),
        .op     (op_q),
        .result (expected)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            op_q       <= '0;
            op_ok_q    <= 1'b0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= op_sel;
                        op_ok_q    <= op_is_legal(op_sel);
                        vec_out    <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= '0;
                        // Illegal ops skip the sweep and report straight away.
                        if (op_is_legal(op_sel)) begin
                            state <= SETTLE_W;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SETTLE_W: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                CHECK: begin
                    if (dut_in != expected) begin
                        err_count <= err_count + (N_IN+1)'(1);
                        if (err_count == '0)
                            first_fail <= vec_out;
                    end
                    if (&vec_out) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else begin
                        vec_out <= vec_out + N_IN'(1);
                        state   <= SETTLE_W;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= op_ok_q && (err_count == '0);
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_tester.sv
// tb_logic_sweep_tester
//   Two testers (N_IN=2/SETTLE=1 and N_IN=3/SETTLE=2) each driving a
//   modelled gate whose behaviour (ideal, stuck, or with injected flips)
//   is chosen per sweep. Expectations come from counting bits of every
//   vector in the sweep.
module tb_logic_sweep_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start;
    logic [2:0] op_sel;

    // gate mode: 0..5 ideal gate of that op, 6 stuck-0, 7 stuck-1,
    // 8..13 ideal gate of op (m-8) with output flipped where fmask is set
    int          gmode [2];
    logic [255:0] fmask [2];

    logic [1:0] vec_a, ff_a;
    logic [2:0] err_a;
    logic [2:0] vec_b, ff_b;
    logic [3:0] err_b;
    logic       dut_in_a, dut_in_b;
    logic       exp_a, busy_a, done_a, pass_a;
    logic       exp_b, busy_b, done_b, pass_b;

    logic [7:0] vec_v [2];
    logic [7:0] err_v [2];
    logic [7:0] ff_v  [2];
    logic       exp_v [2];
    logic       busy_v[2];
    logic       done_v[2];
    logic       pass_v[2];

    int compared = 0;
    int failed   = 0;

    function automatic logic ref_gate(input logic [2:0] op, input int n, input logic [7:0] v);
        int ones;
        logic all1, any1, odd;
        ones = $countones(v);
        all1 = (ones == n);
        any1 = (ones != 0);
        odd  = ((ones % 2) == 1);
        case (op)
            3'd0: return all1;
            3'd1: return any1;
            3'd2: return odd;
            3'd3: return !all1;
            3'd4: return !any1;
            3'd5: return !odd;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic gate_eval(input int m, input int n, input logic [7:0] v, input logic [255:0] mk);
        if (m < 6)  return ref_gate(3'(m), n, v);
        if (m == 6) return 1'b0;
        if (m == 7) return 1'b1;
        return ref_gate(3'(m - 8), n, v) ^ mk[v];
    endfunction

    assign dut_in_a = gate_eval(gmode[0], 2, 8'(vec_a), fmask[0]);
    assign dut_in_b = gate_eval(gmode[1], 3, 8'(vec_b), fmask[1]);

    logic_sweep_tester #(.N_IN(2), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .op_sel(op_sel),
        .vec_out(vec_a), .dut_in(dut_in_a), .expected(exp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail(ff_a)
    );

    logic_sweep_tester #(.N_IN(3), .SETTLE(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .op_sel(op_sel),
        .vec_out(vec_b), .dut_in(dut_in_b), .expected(exp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail(ff_b)
    );

    assign vec_v[0] = 8'(vec_a);  assign vec_v[1] = 8'(vec_b);
    assign err_v[0] = 8'(err_a);  assign err_v[1] = 8'(err_b);
    assign ff_v[0]  = 8'(ff_a);   assign ff_v[1]  = 8'(ff_b);
    assign exp_v[0] = exp_a;      assign exp_v[1] = exp_b;
    assign busy_v[0] = busy_a;    assign busy_v[1] = busy_b;
    assign done_v[0] = done_a;    assign done_v[1] = done_b;
    assign pass_v[0] = pass_a;    assign pass_v[1] = pass_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk every vector, count disagreements between the gate
    // and the requested function.
    task automatic model(input int w, input logic [2:0] op, input int gm,
                         output logic [7:0] e_err, output logic [7:0] e_ff, output logic e_pass);
        int n;
        n = (w == 0) ? 2 : 3;
        e_err = '0;
        e_ff  = '0;
        if (op > 3'd5) begin
            e_pass = 1'b0;
            return;
        end
        for (int v = (1 << n) - 1; v >= 0; v--) begin
            if (gate_eval(gm, n, 8'(v), fmask[w]) != ref_gate(op, n, 8'(v))) begin
                e_err = e_err + 8'd1;
                e_ff  = 8'(v);
            end
        end
        e_pass = (e_err == 0);
    endtask

    task automatic run_sweep(input int w, input logic [2:0] op, input int gm,
                             input logic [7:0] e_err, input logic [7:0] e_ff,
                             input logic e_pass, input string tag);
        int n, st, lat, cyc, bc, limit;
        n     = (w == 0) ? 2 : 3;
        st    = (w == 0) ? 1 : 2;
        lat   = (op <= 3'd5) ? (1 << n) * (st + 1) + 1 : 1;
        limit = lat + 20;
        @(negedge clk);
        gmode[w] = gm;
        op_sel   = op;
        start[w] = 1'b1;
        @(negedge clk);
        start[w] = 1'b0;
        cyc = 0;
        bc  = 0;
        while (!done_v[w] && cyc < limit) begin
            if (busy_v[w]) begin
                bc++;
                chk($sformatf("%s expected@vec%0d", tag, vec_v[w]), 32'(exp_v[w]),
                    32'(ref_gate(op, n, vec_v[w])));
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " busy_cycles"}, bc, lat - 1);
        chk({tag, " err_count"}, 32'(err_v[w]), 32'(e_err));
        chk({tag, " pass"}, 32'(pass_v[w]), 32'(e_pass));
        if (e_err != 0)
            chk({tag, " first_fail"}, 32'(ff_v[w]), 32'(e_ff));
        @(negedge clk);
        chk({tag, " done_width"}, 32'(done_v[w]), 32'd0);
    endtask

    typedef struct {
        int         w;
        logic [2:0] op;
        int         gm;
        logic [7:0] err;
        logic [7:0] ff;
        logic       pass;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int ncyc, ndone, first_done;
        logic [7:0] e_err, e_ff;
        logic e_pass;

        tbl[0] = '{0, 3'd0, 0, 8'd0, 8'd0, 1'b1};  // AND gate, AND op
        tbl[1] = '{0, 3'd1, 6, 8'd3, 8'd1, 1'b0};  // stuck-0 vs OR
        tbl[2] = '{1, 3'd2, 5, 8'd8, 8'd0, 1'b0};  // XNOR gate vs XOR
        tbl[3] = '{0, 3'd7, 0, 8'd0, 8'd0, 1'b0};  // illegal op 7
        tbl[4] = '{0, 3'd6, 0, 8'd0, 8'd0, 1'b0};  // illegal op 6
        tbl[5] = '{0, 3'd3, 7, 8'd1, 8'd3, 1'b0};  // stuck-1 vs NAND
        tbl[6] = '{1, 3'd4, 4, 8'd0, 8'd0, 1'b1};  // NOR gate, NOR op
        tbl[7] = '{1, 3'd0, 6, 8'd1, 8'd7, 1'b0};  // stuck-0 vs AND
        tbl[8] = '{0, 3'd5, 2, 8'd4, 8'd0, 1'b0};  // XOR gate vs XNOR
        tbl[9] = '{1, 3'd1, 3, 8'd2, 8'd0, 1'b0};  // NAND gate vs OR

        rst = 1'b1;
        start = '0;
        op_sel = '0;
        gmode[0] = 0;
        gmode[1] = 0;
        fmask[0] = '0;
        fmask[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset vec_out", 32'(vec_v[0]), 0);
        chk("reset busy", 32'(busy_v[0]), 0);
        chk("reset done", 32'(done_v[0]), 0);
        chk("reset pass", 32'(pass_v[0]), 0);
        chk("reset err_count", 32'(err_v[0]), 0);
        chk("reset first_fail", 32'(ff_v[0]), 0);
        chk("reset busy_b", 32'(busy_v[1]), 0);
        rst = 1'b0;

        foreach (tbl[i])
            run_sweep(tbl[i].w, tbl[i].op, tbl[i].gm, tbl[i].err, tbl[i].ff,
                      tbl[i].pass, $sformatf("tbl%0d", i));

        // Results hold in IDLE after a failing sweep.
        run_sweep(0, 3'd1, 6, 8'd3, 8'd1, 1'b0, "hold_setup");
        repeat (6) @(negedge clk);
        chk("hold err_count", 32'(err_v[0]), 3);
        chk("hold first_fail", 32'(ff_v[0]), 1);
        chk("hold pass", 32'(pass_v[0]), 0);

        // Reset mid-sweep when vec_out reaches 2'b10.
        @(negedge clk);
        gmode[0] = 0; op_sel = 3'd0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        ncyc = 0;
        while (vec_v[0] != 8'd2 && ncyc < 20) begin
            @(negedge clk);
            ncyc++;
        end
        chk("abort reached vec 10", 32'(vec_v[0]), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(busy_v[0]), 0);
        chk("abort vec_out", 32'(vec_v[0]), 0);
        chk("abort pass", 32'(pass_v[0]), 0);
        ndone = 0;
        repeat (15) begin
            if (done_v[0]) ndone++;
            @(negedge clk);
        end
        chk("abort no done", ndone, 0);

        // Reset wins over a simultaneous start.
        rst = 1'b1; start[0] = 1'b1; op_sel = 3'd0;
        @(negedge clk);
        rst = 1'b0; start[0] = 1'b0;
        chk("rst_prio busy", 32'(busy_v[0]), 0);
        ndone = 0;
        repeat (15) begin
            if (done_v[0] || busy_v[0]) ndone++;
            @(negedge clk);
        end
        chk("rst_prio no activity", ndone, 0);

        // Restart and op change mid-sweep are ignored.
        gmode[0] = 1; op_sel = 3'd1; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        ncyc = 0; ndone = 0; first_done = -1;
        while (ncyc < 25) begin
            if (done_v[0]) begin
                ndone++;
                if (first_done < 0) first_done = ncyc;
            end
            if (ncyc == 3) begin op_sel = 3'd5; start[0] = 1'b1; end
            if (ncyc == 4) start[0] = 1'b0;
            @(negedge clk);
            ncyc++;
        end
        chk("restart done count", ndone, 1);
        chk("restart latency", first_done, 9);
        chk("restart pass", 32'(pass_v[0]), 1);
        chk("restart err_count", 32'(err_v[0]), 0);

        // Random sweeps against the counting model.
        for (int k = 0; k < 24; k++) begin
            int w, gm;
            logic [2:0] op;
            w  = int'($urandom_range(0, 1));
            op = 3'($urandom_range(0, 7));
            gm = int'($urandom_range(0, 13));
            for (int j = 0; j < 8; j++)
                fmask[w][j*32 +: 32] = $urandom() & $urandom();
            model(w, op, gm, e_err, e_ff, e_pass);
            run_sweep(w, op, gm, e_err, e_ff, e_pass, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/logic_sweep_tester.md
LOGIC_SWEEP_TESTER -- requirements
Module: logic_sweep_tester

Interface
REQ-001 SHALL have parameter N_IN, default 2, number of gate inputs swept; legal range 1..8.
REQ-002 SHALL have parameter SETTLE, default 1, cycles each vector is held before sampling; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port op_sel  input  3  gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6/7 illegal.
REQ-007 SHALL have port vec_out  output  N_IN  input vector driven to the gate under test.
REQ-008 SHALL have port dut_in  input  1  output of the gate under test.
REQ-009 SHALL have port expected  output  1  reference result for the current vec_out under the latched op.
REQ-010 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-012 SHALL have port pass  output  1  1 when the last sweep had zero mismatches and a legal op.
REQ-013 SHALL have port err_count  output  N_IN+1  mismatch count of the last or current sweep.
REQ-014 SHALL have port first_fail  output  N_IN  vector of the first mismatch; meaningful only when err_count != 0.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE_W, CHECK, DONE.
REQ-016 IDLE, start=1 with a legal op: SHALL latch op_sel, clear vec_out, err_count, first_fail and pass, then go to SETTLE_W.
REQ-017 IDLE, start=1 with op 6/7: SHALL go to DONE with pass=0 and err_count=0.
REQ-018 SETTLE_W SHALL hold vec_out for SETTLE cycles, then go to CHECK.
REQ-019 CHECK SHALL compare dut_in with expected in one cycle.
REQ-020 On a mismatch in CHECK: SHALL increment err_count; if err_count was 0, SHALL capture vec_out into first_fail.
REQ-021 Leaving CHECK: SHALL go to DONE if vec_out is all ones; otherwise SHALL increment vec_out and return to SETTLE_W.
REQ-022 DONE SHALL assert done for exactly one cycle, set pass = (err_count==0) for a legal op, and return to IDLE.
REQ-023 Sweep latency from start-sample edge to done SHALL be 2^N_IN*(SETTLE+1)+1 cycles.
REQ-024 busy SHALL be high in SETTLE_W and CHECK only.
REQ-025 start while not IDLE SHALL be ignored; op_sel changes mid-sweep SHALL be ignored.
REQ-026 err_count width SHALL hold 2^N_IN without overflow; no saturation logic is required.
REQ-027 pass, err_count and first_fail SHALL hold their values in IDLE until the next accepted start.
REQ-028 expected SHALL be the reduction of vec_out by the latched op; NAND, NOR and XNOR SHALL be the inversions of AND, OR and XOR.

Reset
REQ-029 rst=1 SHALL, at the next edge, force state IDLE, vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
REQ-030 rst during a sweep SHALL abort it with no done pulse; rst SHALL take priority over start.

Structure
REQ-031 Op encoding enum and FSM state enum SHALL reside in shared package logic_sweep_pkg.
REQ-032 The reference function SHALL be a combinational sub-module logic_ref_eval (ports: vec, op, result), parametrised by N_IN.

Verification
REQ-033 N_IN=2, SETTLE=1, DUT=AND, op=0, start pulse -> done 9 cycles later, pass=1, err_count=0.
REQ-034 N_IN=2, DUT stuck-at-0, op=1 (OR) -> err_count=3, first_fail=01, pass=0.
REQ-035 N_IN=3, DUT=XNOR, op=2 (XOR) -> err_count=8, first_fail=000, pass=0.
REQ-036 N_IN=2, rst asserted while vec_out=10 -> next cycle busy=0, vec_out=00, no done pulse.
REQ-037 start=1 with op_sel=7 -> done one cycle later, pass=0, err_count=0, busy never high.
REQ-038 start re-pulsed mid-sweep -> ignored; exactly one done pulse at the original latency.
